wb_vector_assembler: RTL and testbench

- Writeback stage sitting directly upstream of the decode-stage register file; produces its write port: scalar/vector write enables, destination select and a vector of write data.
- Two sources of results:
  - ALU results arrive as whole vectors.
  - Memory loads arrive one element per cycle and are gathered into a full vector before a single write is issued.
- Supports flush of an in-flight gather.

---
 rtl/wb_vector_assembler.sv | 141 ++++++++++++++
 tb/tb_wb_vector_assembler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vector_assembler.sv
// Writeback write-port builder: ALU vectors pass straight through, memory elements are gathered into one vector write.
// Latency: 1 cycle from ALU accept, or from the final gathered element, to the registered write pulse.
// Backpressure: wbReady drops for the whole gather; in IDLE one request is accepted per cycle.
module wb_vector_assembler #(
  parameter int registerSize  = 8,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wbValid,
  output logic                                     wbReady,
  input  logic                                     wbIsVec,
  input  logic                                     wbFromMem,
  input  logic [selectionBits-1:0]                 wbDest,
  input  logic [vectorSize-1:0][registerSize-1:0]  wbAluData,
  input  logic                                     memElemValid,
  input  logic [registerSize-1:0]                  memElemData,
  input  logic                                     wbFlush,
  output logic                                     regWrEnSc,
  output logic                                     regWrEnVec,
  output logic [selectionBits-1:0]                 regToWrite,
  output logic [vectorSize-1:0][registerSize-1:0]  dataIn,
  output logic                                     busy
);

  // Lane counter must be able to hold vectorSize itself.
  localparam int CW = $clog2(vectorSize + 1);

  typedef enum logic {IDLE, GATHER} state_t;
  typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;

  state_t                   state;
  logic [CW-1:0]            lane_cnt;
  logic [CW-1:0]            target_cnt;
  vec_t                     gather_buf;
  logic [selectionBits-1:0] dest_q;
  logic                     is_vec_q;

  vec_t                     gather_next;
  vec_t                     alu_scalar;
  vec_t                     mem_scalar;
  logic                     accept;
  logic                     last_elem;

  // Buffer as it would look with the current element dropped into its lane.
  always_comb begin
    gather_next = gather_buf;
    for (int i = 0; i < vectorSize; i++) begin
      if (lane_cnt == CW'(i)) begin
        gather_next[i] = memElemData;
      end
    end
  end

  // Scalar writes only carry lane 0; upper lanes are forced to zero.
  always_comb begin
    alu_scalar    = '0;
    alu_scalar[0] = wbAluData[0];
    mem_scalar    = '0;
    mem_scalar[0] = memElemData;
  end

  // Acceptance is only possible in IDLE; a flush that cycle blocks it.
  always_comb begin
    accept    = wbValid && wbReady && !wbFlush;
    last_elem = memElemValid && ((lane_cnt + CW'(1)) == target_cnt);
  end

  // Main FSM: registered write port, handshake flags and gather state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lane_cnt   <= '0;
      target_cnt <= '0;
      gather_buf <= '0;
      dest_q     <= '0;
      is_vec_q   <= 1'b0;
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
      busy       <= 1'b0;
      wbReady    <= 1'b1;
    end else begin
      // Write enables are single-cycle pulses; data/dest hold otherwise.
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!wbFromMem) begin
              regWrEnVec <= wbIsVec;
              regWrEnSc  <= !wbIsVec;
              regToWrite <= wbDest;
              dataIn     <= wbIsVec ? wbAluData : alu_scalar;
            end else begin
              dest_q     <= wbDest;
              is_vec_q   <= wbIsVec;
              target_cnt <= wbIsVec ? CW'(vectorSize) : CW'(1);
              lane_cnt   <= '0;
              gather_buf <= '0;
              state      <= GATHER;
              busy       <= 1'b1;
              wbReady    <= 1'b0;
            end
          end
        end
        GATHER: begin
          // Flush has priority over a simultaneous final element.
          if (wbFlush) begin
            lane_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            wbReady  <= 1'b1;
          end else if (memElemValid) begin
            gather_buf <= gather_next;
            if (last_elem) begin
              lane_cnt   <= '0;
              regWrEnVec <= is_vec_q;
              regWrEnSc  <= !is_vec_q;
              regToWrite <= dest_q;
              dataIn     <= is_vec_q ? gather_next : mem_scalar;
              state      <= IDLE;
              busy       <= 1'b0;
              wbReady    <= 1'b1;
            end else begin
              lane_cnt <= lane_cnt + CW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          wbReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_vector_assembler.sv
// Bench for wb_vector_assembler: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle to a queue-based model.
`timescale 1ns/1ps
module tb_wb_vector_assembler;

  logic             clk = 1'b0;
  logic             reset;
  logic             wbValid;
  logic             wbReady;
  logic             wbIsVec;
  logic             wbFromMem;
  logic [3:0]       wbDest;
  logic [3:0][7:0]  wbAluData;
  logic             memElemValid;
  logic [7:0]       memElemData;
  logic             wbFlush;
  logic             regWrEnSc;
  logic             regWrEnVec;
  logic [3:0]       regToWrite;
  logic [3:0][7:0]  dataIn;
  logic             busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_vector_assembler #(.registerSize(8), .vectorSize(4), .selectionBits(4)) dut (
    .clk(clk), .reset(reset), .wbValid(wbValid), .wbReady(wbReady),
    .wbIsVec(wbIsVec), .wbFromMem(wbFromMem), .wbDest(wbDest),
    .wbAluData(wbAluData), .memElemValid(memElemValid), .memElemData(memElemData),
    .wbFlush(wbFlush), .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec),
    .regToWrite(regToWrite), .dataIn(dataIn), .busy(busy)
  );

  // Reference model: a pending load is a destination plus a queue of received elements.
  bit         gathering = 0;
  bit         g_vec;
  logic [3:0] g_dest;
  logic [7:0] elems[$];
  logic       exp_sc = 0, exp_vec = 0;
  logic [3:0] exp_dest = 0;
  logic [31:0] exp_data = 0;

  always @(posedge clk) begin
    exp_sc  = 0;
    exp_vec = 0;
    if (!reset) begin
      gathering = 0;
      elems.delete();
      exp_dest = 0;
      exp_data = 0;
    end else if (!gathering) begin
      if (wbValid && !wbFlush) begin
        if (!wbFromMem) begin
          exp_vec  = wbIsVec;
          exp_sc   = !wbIsVec;
          exp_dest = wbDest;
          exp_data = wbIsVec ? 32'(wbAluData) : {24'h0, wbAluData[0]};
        end else begin
          gathering = 1;
          g_vec     = wbIsVec;
          g_dest    = wbDest;
          elems.delete();
        end
      end
    end else begin
      if (wbFlush) begin
        gathering = 0;
        elems.delete();
      end else if (memElemValid) begin
        elems.push_back(memElemData);
        if (elems.size() == (g_vec ? 4 : 1)) begin
          exp_vec  = g_vec;
          exp_sc   = !g_vec;
          exp_dest = g_dest;
          exp_data = 0;
          foreach (elems[i]) exp_data[i*8 +: 8] = elems[i];
          gathering = 0;
          elems.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_sc",    32'(regWrEnSc),  32'(exp_sc));
    check("model_vec",   32'(regWrEnVec), 32'(exp_vec));
    check("model_dest",  32'(regToWrite), 32'(exp_dest));
    check("model_data",  32'(dataIn),     exp_data);
    check("model_busy",  32'(busy),       32'(gathering));
    check("model_ready", 32'(wbReady),    32'(!gathering));
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    wbValid = 0; wbIsVec = 0; wbFromMem = 0; wbDest = 0; wbAluData = '0;
    memElemValid = 0; memElemData = 0; wbFlush = 0;
  endtask

  task automatic start_load(input logic vec, input logic [3:0] dest);
    wbValid = 1; wbFromMem = 1; wbIsVec = vec; wbDest = dest;
    tick();
    wbValid = 0; wbFromMem = 0;
  endtask

  task automatic elem(input logic [7:0] d);
    memElemValid = 1; memElemData = d;
    tick();
    memElemValid = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    // 1. reset
    tick(); tick();
    reset = 1;
    tick();
    check("rst_sc", 32'(regWrEnSc), 0);
    check("rst_vec", 32'(regWrEnVec), 0);
    check("rst_dest", 32'(regToWrite), 0);
    check("rst_data", 32'(dataIn), 0);
    check("rst_ready", 32'(wbReady), 1);
    check("rst_busy", 32'(busy), 0);

    // 2. ALU vector then back-to-back ALU scalar
    wbValid = 1; wbIsVec = 1; wbFromMem = 0; wbDest = 4'h3;
    wbAluData = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    check("alu_vec_en", 32'(regWrEnVec), 1);
    check("alu_vec_dest", 32'(regToWrite), 3);
    check("alu_vec_data", 32'(dataIn), 32'h44332211);
    wbIsVec = 0; wbDest = 4'h5; wbAluData = 32'hDEADBEEF;
    tick();
    check("alu_b2b_sc", 32'(regWrEnSc), 1);
    check("alu_b2b_vec", 32'(regWrEnVec), 0);
    check("alu_b2b_data", 32'(dataIn), 32'h000000EF);
    wbValid = 0;
    tick();
    check("alu_pulse_end", 32'(regWrEnSc), 0);
    check("alu_hold_dest", 32'(regToWrite), 5);

    // Flush in IDLE blocks acceptance
    wbValid = 1; wbFlush = 1; wbIsVec = 1; wbDest = 4'hC;
    tick();
    check("idle_flush_vec", 32'(regWrEnVec), 0);
    idle_inputs();

    // 3. vector load with a gap
    start_load(1, 4'h2);
    check("gath_ready", 32'(wbReady), 0);
    check("gath_busy", 32'(busy), 1);
    elem(8'hA0); elem(8'hA1);
    tick();
    check("gap_busy", 32'(busy), 1);
    elem(8'hA2);
    check("pre_last_vec", 32'(regWrEnVec), 0);
    elem(8'hA3);
    check("vload_en", 32'(regWrEnVec), 1);
    check("vload_data", 32'(dataIn), 32'hA3A2A1A0);
    check("vload_dest", 32'(regToWrite), 2);
    check("vload_ready", 32'(wbReady), 1);

    // 4. scalar load
    start_load(0, 4'h9);
    elem(8'h7F);
    check("sload_en", 32'(regWrEnSc), 1);
    check("sload_data", 32'(dataIn), 32'h0000007F);
    check("sload_busy", 32'(busy), 0);

    // 5. flush with the last element
    start_load(1, 4'h6);
    elem(8'h01); elem(8'h02); elem(8'h03);
    wbFlush = 1;
    elem(8'h04);
    wbFlush = 0;
    check("flush_vec", 32'(regWrEnVec), 0);
    check("flush_busy", 32'(busy), 0);
    wbValid = 1; wbIsVec = 1; wbDest = 4'h1; wbAluData = 32'h01020304;
    tick();
    wbValid = 0;
    check("post_flush_en", 32'(regWrEnVec), 1);
    check("post_flush_data", 32'(dataIn), 32'h01020304);

    // 6. reset mid-gather
    start_load(1, 4'h7);
    elem(8'hB0); elem(8'hB1);
    reset = 0;
    tick();
    reset = 1;
    check("mid_rst_vec", 32'(regWrEnVec), 0);
    check("mid_rst_data", 32'(dataIn), 0);
    check("mid_rst_busy", 32'(busy), 0);
    start_load(0, 4'hA);
    elem(8'h5A);
    check("after_rst_sc", 32'(regWrEnSc), 1);
    check("after_rst_data", 32'(dataIn), 32'h0000005A);
    check("after_rst_dest", 32'(regToWrite), 4'hA);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wbValid      = ($urandom_range(0, 2) != 0);
      wbIsVec      = $urandom_range(0, 1);
      wbFromMem    = $urandom_range(0, 1);
      wbDest       = 4'($urandom);
      wbAluData    = $urandom;
      memElemValid = ($urandom_range(0, 3) != 0);
      memElemData  = 8'($urandom);
      wbFlush      = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
